// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution stage.
// Holds the op-kind encoding, the branch funct3 encodings and the
// resolver state enumeration so every file agrees on them.
package branch_resolve_pkg;

    // Op kind as presented by issue on in_kind.
    typedef enum logic [1:0] {
        KindNone   = 2'b00,
        KindBranch = 2'b01,
        KindJal    = 2'b10,
        KindJalr   = 2'b11
    } kind_e;

    // Branch condition encodings (RV32I funct3).
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // EMPTY: no entry; BUSY: entry with result pending; REDIR: result
    // retired to writeback, redirect still waiting on fetch.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b01,
        StRedir = 2'b10
    } state_e;

endpackage

// File: rtl/branch_resolve_cu.sv
// Branch comparator unit.
// Ports:
//   a_i, b_i     operands (rs1, rs2)
//   lt_i         1: less-than compare, 0: equality compare
//   invert_i     invert the raw compare result (BNE/BGE/BGEU)
//   unsigned_i   less-than compare is unsigned
//   result_o     condition outcome
module branch_resolve_cu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             lt_i,
    input  logic             invert_i,
    input  logic             unsigned_i,
    output logic             result_o
);

    logic eq;
    logic less;

    always_comb begin
        eq = (a_i == b_i);
        if (unsigned_i) begin
            less = (a_i < b_i);
        end else begin
            less = ($signed(a_i) < $signed(b_i));
        end
        result_o = (lt_i ? less : eq) ^ invert_i;
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch/jump resolution stage with a one-entry result buffer.
// Captures an op, resolves taken/target/link, then hands the result to
// writeback (out_*) and, when taken and aligned, a redirect to fetch
// (redirect_*). The two handshakes complete independently.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            issue handshake
//   in_kind, in_funct3           op kind and branch condition
//   in_pc, in_imm, in_ra, in_rb  op PC, offset and operands
//   out_valid/out_ready          writeback handshake
//   out_taken, out_link          outcome and pc+4
//   out_illegal, out_misaligned  exception flags
//   redirect_valid/ready, _pc    fetch redirect handshake and target
//   flush                        one-cycle kill after redirect accepted
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       in_funct3,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [WIDTH-1:0] in_ra,
    input  logic [WIDTH-1:0] in_rb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [WIDTH-1:0] out_link,
    output logic             out_illegal,
    output logic             out_misaligned,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             flush
);

    kind_e kind;
    logic  cmp_lt, cmp_invert, cmp_unsigned, cmp_result, f3_illegal;
    logic  taken_c, illegal_c, misal_c;
    logic  [WIDTH-1:0] sum_base, target_sum, target_c;

    state_e state_q, state_d;
    logic   out_pend_q, out_pend_d;
    logic   redir_pend_q, redir_pend_d;
    logic   flush_q, flush_d;
    logic   taken_q, illegal_q, misal_q;
    logic   [WIDTH-1:0] link_q, target_q;

    logic capture, out_fire, redir_fire, retire;

    assign kind = kind_e'(in_kind);

    always_comb begin
        cmp_lt       = 1'b0;
        cmp_invert   = 1'b0;
        cmp_unsigned = 1'b0;
        f3_illegal   = 1'b0;
        case (in_funct3)
            F3_BEQ:  ;
            F3_BNE:  cmp_invert = 1'b1;
            F3_BLT:  cmp_lt = 1'b1;
            F3_BGE:  begin cmp_lt = 1'b1; cmp_invert = 1'b1; end
            F3_BLTU: begin cmp_lt = 1'b1; cmp_unsigned = 1'b1; end
            F3_BGEU: begin cmp_lt = 1'b1; cmp_invert = 1'b1; cmp_unsigned = 1'b1; end
            default: f3_illegal = 1'b1;
        endcase
    end

    branch_resolve_cu #(
        .WIDTH(WIDTH)
    ) u_cu (
        .a_i       (in_ra),
        .b_i       (in_rb),
        .lt_i      (cmp_lt),
        .invert_i  (cmp_invert),
        .unsigned_i(cmp_unsigned),
        .result_o  (cmp_result)
    );

    always_comb begin
        taken_c = 1'b0;
        case (kind)
            KindBranch:       taken_c = cmp_result && !f3_illegal;
            KindJal, KindJalr: taken_c = 1'b1;
            default:          taken_c = 1'b0;
        endcase
        illegal_c  = (kind == KindBranch) && f3_illegal;
        sum_base   = (kind == KindJalr) ? in_ra : in_pc;
        target_sum = sum_base + in_imm;
        target_c   = (kind == KindJalr) ? {target_sum[WIDTH-1:1], 1'b0} : target_sum;
        misal_c    = taken_c && (target_c[1:0] != 2'b00);
    end

    assign out_fire   = out_pend_q && out_ready;
    assign redir_fire = redir_pend_q && redirect_ready;
    // Entry retires once each pending bit is already clear or clears now.
    assign retire     = (state_q != StEmpty) && (!out_pend_q || out_fire)
                        && (!redir_pend_q || redir_fire);

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            StEmpty: in_ready = 1'b1;
            StBusy:  in_ready = retire && !redir_pend_q;
            default: in_ready = 1'b0;
        endcase
    end

    assign capture = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        out_pend_d   = out_pend_q && !out_fire;
        redir_pend_d = redir_pend_q && !redir_fire;
        flush_d      = redir_fire;
        if (capture) begin
            out_pend_d   = 1'b1;
            redir_pend_d = taken_c && !misal_c;
        end
        case (state_q)
            StEmpty: if (capture) state_d = StBusy;
            StBusy: begin
                if (retire) begin
                    state_d = capture ? StBusy : StEmpty;
                end else if (out_fire && redir_pend_q) begin
                    state_d = StRedir;
                end
            end
            StRedir: if (redir_fire) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            out_pend_q   <= 1'b0;
            redir_pend_q <= 1'b0;
            flush_q      <= 1'b0;
            taken_q      <= 1'b0;
            illegal_q    <= 1'b0;
            misal_q      <= 1'b0;
            link_q       <= '0;
            target_q     <= '0;
        end else begin
            state_q      <= state_d;
            out_pend_q   <= out_pend_d;
            redir_pend_q <= redir_pend_d;
            flush_q      <= flush_d;
            if (capture) begin
                taken_q   <= taken_c;
                illegal_q <= illegal_c;
                misal_q   <= misal_c;
                link_q    <= in_pc + WIDTH'(4);
                target_q  <= target_c;
            end
        end
    end

    assign out_valid      = out_pend_q;
    assign redirect_valid = redir_pend_q;
    assign out_taken      = taken_q;
    assign out_illegal    = illegal_q;
    assign out_misaligned = misal_q;
    assign out_link       = link_q;
    assign redirect_pc    = target_q;
    assign flush          = flush_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: scenario tasks with a scoreboard
// queue of expected results pushed at capture and popped at writeback.
module tb_branch_resolve;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic         taken;
        logic         illegal;
        logic         misal;
        logic         redir;
        logic [W-1:0] link;
        logic [W-1:0] target;
    } exp_t;

    logic         clk, rst_n;
    logic         in_valid, in_ready;
    logic [1:0]   in_kind;
    logic [2:0]   in_funct3;
    logic [W-1:0] in_pc, in_imm, in_ra, in_rb;
    logic         out_valid, out_ready, out_taken, out_illegal, out_misaligned;
    logic [W-1:0] out_link, redirect_pc;
    logic         redirect_valid, redirect_ready, flush;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    branch_resolve #(
        .WIDTH(W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_kind       (in_kind),
        .in_funct3     (in_funct3),
        .in_pc         (in_pc),
        .in_imm        (in_imm),
        .in_ra         (in_ra),
        .in_rb         (in_rb),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_taken     (out_taken),
        .out_link      (out_link),
        .out_illegal   (out_illegal),
        .out_misaligned(out_misaligned),
        .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready),
        .redirect_pc   (redirect_pc),
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [1:0] kind, input logic [2:0] f3,
                                   input logic [W-1:0] pc, input logic [W-1:0] imm,
                                   input logic [W-1:0] ra, input logic [W-1:0] rb);
        exp_t e;
        logic [W-1:0] tgt;
        e.taken   = 1'b0;
        e.illegal = 1'b0;
        e.link    = pc + 32'd4;
        tgt       = pc + imm;
        case (kind)
            2'b01: begin
                case (f3)
                    3'b000:  e.taken = (ra == rb);
                    3'b001:  e.taken = (ra != rb);
                    3'b100:  e.taken = ($signed(ra) < $signed(rb));
                    3'b101:  e.taken = ($signed(ra) >= $signed(rb));
                    3'b110:  e.taken = (ra < rb);
                    3'b111:  e.taken = (ra >= rb);
                    default: e.illegal = 1'b1;
                endcase
            end
            2'b10: e.taken = 1'b1;
            2'b11: begin
                e.taken = 1'b1;
                tgt     = (ra + imm) & ~32'd1;
            end
            default: e.taken = 1'b0;
        endcase
        e.target = tgt;
        e.misal  = e.taken && (tgt[1:0] != 2'b00);
        e.redir  = e.taken && !e.misal;
        return e;
    endfunction

    // Enter just after a rising edge.
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offer one op, wait (bounded) for acceptance, record its expected result.
    task automatic drive_op(input logic [1:0] kind, input logic [2:0] f3,
                            input logic [W-1:0] pc, input logic [W-1:0] imm,
                            input logic [W-1:0] ra, input logic [W-1:0] rb);
        int n = 0;
        in_kind = kind; in_funct3 = f3; in_pc = pc; in_imm = imm; in_ra = ra; in_rb = rb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end
        sb.push_back(model(kind, f3, pc, imm, ra, rb));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_redir_valid: got %b want 0", redirect_valid); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush: got %b want 0", flush); end
        total++; if ({out_taken, out_illegal, out_misaligned} !== 3'b000) begin
            bad++; $display("FAIL rst_flags: got %b want 000", {out_taken, out_illegal, out_misaligned});
        end
        total++; if (out_link !== '0 || redirect_pc !== '0) begin
            bad++; $display("FAIL rst_payload: got link=%h pc=%h want 0 0", out_link, redirect_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_beq_flush();
        exp_t e;
        sync();
        out_ready = 1'b1; redirect_ready = 1'b0;
        drive_op(2'b01, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
        e = sb.pop_front();
        total++; if (out_valid !== 1'b1 || out_taken !== e.taken) begin
            bad++; $display("FAIL beq_taken: got v=%b t=%b want v=1 t=%b", out_valid, out_taken, e.taken);
        end
        total++; if (redirect_pc !== e.target || out_link !== e.link) begin
            bad++; $display("FAIL beq_payload: got pc=%h link=%h want %h %h", redirect_pc, out_link, e.target, e.link);
        end
        total++; if (redirect_valid !== e.redir) begin bad++; $display("FAIL beq_redir: got %b want %b", redirect_valid, e.redir); end
        sync();
        total++; if (out_valid !== 1'b0 || redirect_valid !== 1'b1 || flush !== 1'b0) begin
            bad++; $display("FAIL beq_wait: got ov=%b rv=%b fl=%b want 0 1 0", out_valid, redirect_valid, flush);
        end
        redirect_ready = 1'b1;
        sync();
        total++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL beq_flush: got fl=%b rv=%b want 1 0", flush, redirect_valid);
        end
        redirect_ready = 1'b0;
        sync();
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL beq_flush_once: got %b want 0", flush); end
    endtask

    task automatic test_compare();
        exp_t e;
        out_ready = 1'b1; redirect_ready = 1'b1;
        drive_op(2'b01, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        e = sb.pop_front();
        total++; if (out_taken !== e.taken || redirect_valid !== e.redir) begin
            bad++; $display("FAIL blt_signed: got t=%b rv=%b want %b %b", out_taken, redirect_valid, e.taken, e.redir);
        end
        sync();
        drive_op(2'b01, 3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        e = sb.pop_front();
        total++; if (out_valid !== 1'b1 || out_taken !== e.taken || redirect_valid !== e.redir) begin
            bad++; $display("FAIL bltu: got v=%b t=%b rv=%b want 1 %b %b", out_valid, out_taken, redirect_valid, e.taken, e.redir);
        end
        sync();
        drive_op(2'b01, 3'b010, 32'h210, 32'h8, 32'd3, 32'd3);
        e = sb.pop_front();
        total++; if (out_illegal !== e.illegal || out_taken !== e.taken || redirect_valid !== e.redir) begin
            bad++; $display("FAIL illegal_f3: got il=%b t=%b rv=%b want %b %b %b", out_illegal, out_taken,
                            redirect_valid, e.illegal, e.taken, e.redir);
        end
        sync();
    endtask

    task automatic test_jalr_misaligned();
        exp_t e;
        out_ready = 1'b1; redirect_ready = 1'b1;
        drive_op(2'b11, 3'b000, 32'h300, 32'h0, 32'h203, 32'h0);
        e = sb.pop_front();
        total++; if (redirect_pc !== e.target || out_misaligned !== e.misal) begin
            bad++; $display("FAIL jalr_target: got pc=%h mis=%b want %h %b", redirect_pc, out_misaligned, e.target, e.misal);
        end
        total++; if (redirect_valid !== e.redir || out_link !== e.link) begin
            bad++; $display("FAIL jalr_link: got rv=%b link=%h want %b %h", redirect_valid, out_link, e.redir, e.link);
        end
        sync();
    endtask

    task automatic test_redir_stall();
        exp_t e;
        out_ready = 1'b0; redirect_ready = 1'b0;
        drive_op(2'b01, 3'b001, 32'h400, 32'hFFFF_FFF8, 32'd1, 32'd2);
        e = sb.pop_front();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_link !== e.link || redirect_pc !== e.target) begin
                bad++; $display("FAIL out_hold: got v=%b rdy=%b link=%h pc=%h want 1 0 %h %h", out_valid, in_ready,
                                out_link, redirect_pc, e.link, e.target);
            end
        end
        out_ready = 1'b1;
        total++; if (out_taken !== e.taken) begin bad++; $display("FAIL stall_taken: got %b want %b", out_taken, e.taken); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b0 || redirect_valid !== 1'b1 || out_valid !== 1'b0 || redirect_pc !== e.target) begin
                bad++; $display("FAIL redir_hold: got rdy=%b rv=%b ov=%b pc=%h want 0 1 0 %h", in_ready, redirect_valid,
                                out_valid, redirect_pc, e.target);
            end
        end
        redirect_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || flush !== 1'b1 || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL redir_release: got rdy=%b fl=%b rv=%b want 1 1 0", in_ready, flush, redirect_valid);
        end
        redirect_ready = 1'b0;
        sync();
    endtask

    task automatic test_back_to_back();
        localparam int N = 8;
        exp_t e;
        int   got = 0;
        logic [W-1:0] a;
        out_ready = 1'b1; redirect_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            a = $urandom;
            in_valid  = 1'b1;
            in_kind   = 2'b01;
            in_pc     = 32'h1000 + 32'(i * 4);
            in_imm    = 32'h80;
            in_ra     = a;
            in_funct3 = (i % 2 == 0) ? 3'b000 : 3'b001;
            in_rb     = (i % 2 == 0) ? (a ^ 32'd1) : a;
            @(negedge clk);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
            if (out_valid === 1'b1) begin
                e = sb.pop_front();
                got++;
                total++; if (out_taken !== e.taken || out_link !== e.link || redirect_valid !== e.redir) begin
                    bad++; $display("FAIL b2b_out[%0d]: got t=%b link=%h rv=%b want %b %h %b", i, out_taken, out_link,
                                    redirect_valid, e.taken, e.link, e.redir);
                end
            end
            sb.push_back(model(in_kind, in_funct3, in_pc, in_imm, in_ra, in_rb));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        if (out_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            got++;
            total++; if (out_link !== e.link || out_taken !== e.taken) begin
                bad++; $display("FAIL b2b_last: got link=%h t=%b want %h %b", out_link, out_taken, e.link, e.taken);
            end
        end
        total++; if (got !== N) begin bad++; $display("FAIL b2b_count: got %0d want %0d", got, N); end
        sb.delete();
        sync();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        out_ready = 1'b0; redirect_ready = 1'b0;
        drive_op(2'b10, 3'b000, 32'h500, 32'h40, 32'h0, 32'h0);
        e = sb.pop_front();
        total++; if (redirect_valid !== e.redir || redirect_pc !== e.target) begin
            bad++; $display("FAIL jal_pending: got rv=%b pc=%h want %b %h", redirect_valid, redirect_pc, e.redir, e.target);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (redirect_valid !== 1'b0 || out_valid !== 1'b0 || redirect_pc !== '0) begin
            bad++; $display("FAIL mid_reset: got rv=%b ov=%b pc=%h want 0 0 0", redirect_valid, out_valid, redirect_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset: got rdy=%b ov=%b want 1 0", in_ready, out_valid);
        end
        sync();
        out_ready = 1'b1; redirect_ready = 1'b1;
        drive_op(2'b01, 3'b101, 32'h600, 32'h10, 32'd7, 32'hFFFF_FFF0);
        e = sb.pop_front();
        total++; if (out_taken !== e.taken || redirect_pc !== e.target || out_link !== e.link) begin
            bad++; $display("FAIL post_reset_op: got t=%b pc=%h link=%h want %b %h %h", out_taken, redirect_pc,
                            out_link, e.taken, e.target, e.link);
        end
        sync();
    endtask

    initial begin
        in_valid = 1'b0; in_kind = 2'b00; in_funct3 = 3'b000;
        in_pc = '0; in_imm = '0; in_ra = '0; in_rb = '0;
        out_ready = 1'b0; redirect_ready = 1'b0;
        test_reset();
        test_beq_flush();
        test_compare();
        test_jalr_misaligned();
        test_redir_stall();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (PC, operands, immediate).
REQ-002 SHALL have ports (name direction width meaning):
- clk in 1: sole clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- in_valid in 1: issue offers an op.
- in_ready out 1: stage accepts the op.
- in_kind in 2: 00 none, 01 branch, 10 jal, 11 jalr.
- in_funct3 in 3: branch condition.
- in_pc in WIDTH: op PC.
- in_imm in WIDTH: sign-extended offset.
- in_ra in WIDTH: rs1 value.
- in_rb in WIDTH: rs2 value.
- out_valid out 1: result available to writeback.
- out_ready in 1: writeback accepts.
- out_taken out 1: control transfer taken.
- out_link out WIDTH: pc+4.
- out_illegal out 1: funct3 010/011 on a branch.
- out_misaligned out 1: taken target bits [1:0] nonzero.
- redirect_valid out 1: fetch redirect request.
- redirect_ready in 1: fetch accepts redirect.
- redirect_pc out WIDTH: redirect target.
- flush out 1: one-cycle kill of younger ops.

Function
REQ-003 SHALL decode branch funct3 into comparator controls:
- 000 BEQ: lt=0, invert=0.
- 001 BNE: lt=0, invert=1.
- 100 BLT: lt=1, invert=0, signed.
- 101 BGE: lt=1, invert=1, signed.
- 110 BLTU / 111 BGEU: as BLT/BGE, unsigned.
REQ-004 SHALL treat branch funct3 010/011 as not taken with out_illegal=1.
REQ-005 SHALL set taken: jal/jalr always 1; branch = comparator result; kind 00 = 0.
REQ-006 SHALL compute target: branch/jal in_pc+in_imm; jalr (in_ra+in_imm) with bit0 cleared; all sums modulo 2^WIDTH.
REQ-007 SHALL compute out_link = in_pc+4, modulo 2^WIDTH.
REQ-008 SHALL capture an op when in_valid && in_ready; captured results appear on outputs the next cycle (latency 1) and stay stable until retired.
REQ-009 SHALL, on capture, set out-pending=1 and redirect-pending=taken && !misaligned; out_valid mirrors out-pending, redirect_valid mirrors redirect-pending.
REQ-010 SHALL clear out-pending on out_valid && out_ready and redirect-pending on redirect_valid && redirect_ready; the two handshakes are independent and may complete in the same or different cycles.
REQ-011 SHALL retire the entry when both pending bits are clear or clearing this cycle.
REQ-012 SHALL implement state machine EMPTY / BUSY / REDIR:
- EMPTY -> BUSY on capture.
- BUSY -> EMPTY on retire with no new capture.
- BUSY -> BUSY on retire plus same-cycle capture.
- BUSY -> REDIR when out completes while redirect is still pending.
- REDIR -> EMPTY on redirect handshake.
REQ-013 SHALL drive in_ready=1 in EMPTY; in BUSY only if retiring this cycle and redirect-pending=0; in REDIR 0.
REQ-014 SHALL pulse flush high for exactly the cycle after a redirect handshake completes.
REQ-015 SHALL force out_misaligned=0 when not taken; a misaligned taken op raises no redirect.
REQ-016 SHALL hold out_valid, redirect_valid and their payloads constant while stalled by the consumer.

Reset
REQ-017 SHALL, on rst_n low, asynchronously enter EMPTY and clear out_valid, redirect_valid, flush, out_taken, out_illegal and out_misaligned; out_link and redirect_pc reset to 0.
REQ-018 SHALL discard any in-flight op on reset mid-operation; no handshake completes while rst_n is low.

Structure
REQ-019 SHALL place the in_kind encodings, the funct3 encodings and the state enumeration in the shared core package.
REQ-020 SHALL instantiate the existing cu comparator as its single sub-module, with WIDTH passed through.

Verification
REQ-021 BEQ ra=5, rb=5, pc=0x100, imm=0x20 -> next cycle out_taken=1, redirect_pc=0x120; flush one cycle after redirect handshake.
REQ-022 BLT ra=0xFFFFFFFF, rb=1 -> taken; BLTU same operands -> not taken, no redirect_valid.
REQ-023 JALR ra=0x203, imm=0 -> redirect_pc=0x202, out_misaligned=1, no redirect; out_link=pc+4.
REQ-024 Taken branch, out_ready=1, redirect_ready=0 for 3 cycles -> REDIR state, in_ready=0, redirect_pc stable; in_ready returns after handshake.
REQ-025 Back-to-back not-taken branches with out_ready=1 -> one op accepted per cycle, no bubbles.
REQ-026 rst_n low while redirect pending -> redirect_valid=0 and out_valid=0 immediately; after release state EMPTY with in_ready=1.
